// File: rtl/fp32_to_int32_seq.sv
// Multi-cycle fp32 -> int32 converter, truncating toward zero.
// One alignment shift per clock, single operation in flight, valid/ready on both sides.
module fp32_to_int32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        overflow,
  output logic        inexact
);

  localparam int unsigned INT_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned CNT_W  = 5;

  localparam logic [EXP_W-1:0] EXP_BIAS  = EXP_W'(127);
  localparam logic [EXP_W-1:0] EXP_ALIGN = EXP_W'(150);  // exponent at which 1.M is already an integer
  localparam logic [EXP_W-1:0] EXP_SAT   = EXP_W'(158);
  localparam logic [EXP_W-1:0] EXP_SPEC  = EXP_W'(255);

  localparam logic [INT_W-1:0] INT_MAX = INT_W'(32'h7FFF_FFFF);
  localparam logic [INT_W-1:0] INT_MIN = INT_W'(32'h8000_0000);

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    FINISH,
    DONE
  } state_t;

  state_t              state, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [INT_W-1:0]    work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                left_q, left_d;
  logic                sticky_q, sticky_d;
  logic                sat_q, sat_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_d;
  logic [INT_W-1:0]    int_out_d;
  logic                overflow_d;
  logic                inexact_d;

  // Operand classification, decoded from the latched fields
  logic                is_nan;
  logic                is_neg_min;
  logic                is_too_big;
  logic                is_small;
  logic                shift_left;
  logic [EXP_W-1:0]    shift_amt;
  logic [INT_W-1:0]    sat_word;

  always_comb begin
    is_nan     = (exp_q == EXP_SPEC) && (mant_q != '0);
    is_neg_min = sign_q && (exp_q == EXP_SAT) && (mant_q == '0);
    is_too_big = (exp_q >= EXP_SAT) && !is_neg_min;
    is_small   = (exp_q < EXP_BIAS);
    shift_left = (exp_q > EXP_ALIGN);
    shift_amt  = shift_left ? EXP_W'(exp_q - EXP_ALIGN) : EXP_W'(EXP_ALIGN - exp_q);
    sat_word   = (sign_q && !is_nan) ? INT_MIN : INT_MAX;
  end

  assign in_ready = (state == IDLE);

  // Next-state and datapath update
  always_comb begin
    state_d     = state;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sticky_d    = sticky_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid;
    int_out_d   = int_out;
    overflow_d  = overflow;
    inexact_d   = inexact;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d  = fp_in[31];
          exp_d   = fp_in[30:23];
          mant_d  = fp_in[22:0];
          state_d = CLASSIFY;
        end
      end

      CLASSIFY: begin
        sticky_d = 1'b0;
        sat_d    = 1'b0;
        ovf_d    = 1'b0;
        cnt_d    = '0;
        left_d   = 1'b0;
        if (is_too_big) begin
          work_d  = sat_word;
          sat_d   = 1'b1;
          ovf_d   = 1'b1;
          state_d = FINISH;
        end else if (is_neg_min) begin
          work_d  = INT_MIN;
          sat_d   = 1'b1;
          state_d = FINISH;
        end else if (is_small) begin
          work_d   = '0;
          sticky_d = (exp_q != '0) || (mant_q != '0);
          state_d  = FINISH;
        end else begin
          work_d  = {8'b0, 1'b1, mant_q};
          left_d  = shift_left;
          cnt_d   = CNT_W'(shift_amt);
          state_d = (shift_amt == '0) ? FINISH : SHIFT;
        end
      end

      SHIFT: begin
        if (left_q) begin
          work_d = {work_q[INT_W-2:0], 1'b0};
        end else begin
          work_d   = {1'b0, work_q[INT_W-1:1]};
          sticky_d = sticky_q | work_q[0];
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Saturated words are already in final two's-complement form
        int_out_d   = (sign_q && !sat_q) ? (~work_q + INT_W'(1)) : work_q;
        overflow_d  = ovf_q;
        inexact_d   = sticky_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      sticky_q  <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      int_out   <= '0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      state     <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      sticky_q  <= sticky_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      out_valid <= out_valid_d;
      int_out   <= int_out_d;
      overflow  <= overflow_d;
      inexact   <= inexact_d;
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Scoreboard bench for fp32_to_int32_seq: directed corner cases, random operands,
// backpressure and mid-operation reset.
module tb_fp32_to_int32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        overflow;
  logic        inexact;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    logic        inx;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_t = 0;
  int   rise = 0;
  logic ov_prev = 1'b0;

  fp32_to_int32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Independent reference: wide shift of 1.M, then negate
  function automatic exp_t model(input logic [31:0] f);
    exp_t        r;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] mag;
    int          sh;
    s = f[31];
    e = f[30:23];
    m = f[22:0];
    r.val = 32'h0; r.ovf = 1'b0; r.inx = 1'b0; r.lat = 3; r.t = 0;
    if (e == 8'hFF) begin
      r.ovf = 1'b1;
      r.val = (m != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (e < 8'd127) begin
      r.inx = (f[30:0] != 0);
    end else if (e >= 8'd158) begin
      if (s && e == 8'd158 && m == 0) r.val = 32'h80000000;
      else begin
        r.ovf = 1'b1;
        r.val = s ? 32'h80000000 : 32'h7FFFFFFF;
      end
    end else begin
      mag = {40'd0, 1'b1, m};
      sh  = int'(e) - 150;
      if (sh >= 0) mag = mag << sh;
      else begin
        r.inx = ((mag & ((64'd1 << (-sh)) - 64'd1)) != 64'd0);
        mag   = mag >> (-sh);
      end
      r.lat = 3 + ((sh < 0) ? -sh : sh);
      r.val = s ? 32'(-mag) : mag[31:0];
    end
    return r;
  endfunction

  // Input changes happen 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f, input exp_t e);
    int g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    fp_in    = f;
    e.t      = cyc;
    last_t   = cyc;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // Output monitor: compare every completed result with the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !ov_prev) rise = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_result", int_out, 32'hDEADBEEF);
        end else begin
          e = q.pop_front();
          check("int_out", int_out, e.val);
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("inexact", 32'(inexact), 32'(e.inx));
          check("latency", 32'(rise - e.t), 32'(e.lat));
        end
      end
    end else begin
      ov_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d_in  [15];
    logic [31:0] d_val [15];
    logic        d_ovf [15];
    logic        d_inx [15];
    int          d_lat [15];
    exp_t        e;
    logic [31:0] r;
    int          g;

    d_in  = '{32'h40490FDB, 32'hC7C35000, 32'h4EFFFFFF, 32'h4F000000, 32'hCF000000,
              32'h7FC00000, 32'hFF800000, 32'h3F000000, 32'h00000000, 32'h80000000,
              32'h4B000000, 32'h3F800000, 32'h7F800000, 32'hCF000001, 32'h00000001};
    d_val = '{32'h00000003, 32'hFFFE7960, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000,
              32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000,
              32'h00800000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    d_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    d_inx = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    d_lat = '{25, 10, 10, 3, 3, 3, 3, 3, 3, 3, 3, 26, 3, 3, 3};

    rst = 1'b1; in_valid = 1'b0; fp_in = 32'h0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_int_out", int_out, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_inexact", 32'(inexact), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Directed corner cases
    for (int i = 0; i < 15; i++) begin
      e.val = d_val[i]; e.ovf = d_ovf[i]; e.inx = d_inx[i]; e.lat = d_lat[i]; e.t = 0;
      send(d_in[i], e);
    end
    drain();

    // Random operands concentrated around the interesting exponent range
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (i % 8 != 7) r[30:23] = 8'($urandom_range(160, 118));
      send(r, model(r));
    end
    drain();

    // Backpressure: result held, concurrent input ignored
    out_ready = 1'b0;
    e.val = 32'h3; e.ovf = 1'b0; e.inx = 1'b1; e.lat = 25; e.t = 0;
    send(32'h40490FDB, e);
    g = 0;
    while (!out_valid && g < 100) begin
      tick();
      g++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    fp_in    = 32'h3F800000;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_val", int_out, 32'h3);
      check("bp_hold_inexact", 32'(inexact), 32'd1);
      check("bp_hold_overflow", 32'(overflow), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_queue_empty", 32'(q.size()), 32'd0);
    e.val = 32'h1; e.ovf = 1'b0; e.inx = 1'b0; e.lat = 26; e.t = 0;
    send(32'h3F800000, e);
    drain();

    // Reset in the middle of the shift phase
    e.val = 32'h3; e.ovf = 1'b0; e.inx = 1'b1; e.lat = 25; e.t = 0;
    send(32'h40490FDB, e);
    while (cyc < last_t + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_int_out", int_out, 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_inexact", 32'(inexact), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    g = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) g++;
      tick();
    end
    check("mid_rst_no_stale", 32'(g), 32'd0);
    e.val = 32'hFFFE7960; e.ovf = 1'b0; e.inx = 1'b0; e.lat = 10; e.t = 0;
    send(32'hC7C35000, e);
    drain();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_to_int32_seq.md
Name: fp32_to_int32_seq

Overview:
- Multi-cycle converter from IEEE-754 single precision to a 32-bit two's-complement integer, rounding toward zero.
- Consumes results from the team's fp32 adder datapath and returns them to the integer domain.
- Shift-and-add style, one bit of alignment per clock, with valid/ready handshakes on both sides.
- Holds one operation in flight; no pipelining.

Parameters:
- None. Widths are fixed: 32-bit float in, 32-bit signed integer out.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  fp_in is valid
- in_ready  output  1  block can accept an operand (combinational decode of state==IDLE)
- fp_in  input  32  operand {sign[31], exp[30:23], mant[22:0]}
- out_valid  output  1  int_out and flags are valid
- out_ready  input  1  consumer accepts the result
- int_out  output  32  signed result, truncated toward zero
- overflow  output  1  NaN, infinity or out-of-range operand; int_out is saturated
- inexact  output  1  nonzero fraction bits were discarded

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, int_out=0, overflow=0, inexact=0. in_ready reads 1 during and after reset.
- rst overrides everything in any state. An in-flight operation is discarded and no result is produced.
- States: IDLE, CLASSIFY, SHIFT, FINISH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (cycle T): latch sign S, exponent E, mantissa M; go to CLASSIFY.
  - in_valid while not in IDLE is ignored.
- CLASSIFY (T+1): let e = E-127.
  - E=255 and M!=0 (NaN): result 0x7FFFFFFF, overflow=1.
  - E=255 and M=0 (infinity): result S ? 0x80000000 : 0x7FFFFFFF, overflow=1.
  - E>=158, except S=1, E=158, M=0: saturate by sign as for infinity, overflow=1.
  - S=1, E=158, M=0: result 0x80000000, overflow=0, inexact=0.
  - E<127, denormals included: result 0, inexact = (E!=0 || M!=0).
  - Special cases skip SHIFT and go to FINISH.
  - 127<=E<=157: working reg W = {8'b0, 1'b1, M}, N = |e-23|, direction left if e>23, right if e<23.
  - If N=0 go to FINISH, else go to SHIFT.
- SHIFT:
  - One 1-bit shift of W per cycle; down-counter decrements each cycle.
  - On a right shift, the bit shifted out is ORed into a sticky flag that becomes inexact.
  - Exit to FINISH after exactly N cycles.
- FINISH: if S=1 and not saturated, int_out = ~W+1, else int_out = W. Flags registered. Go to DONE.
- DONE:
  - out_valid=1.
  - int_out and flags stay stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE; in_ready=1 the next cycle.
  - out_valid deasserts on the cycle after the handshake.
- Latency: out_valid first high at T+3+N. N=0 for special cases and e=23. Maximum N=23 (e=0).
- Arithmetic: magnitudes never exceed 2^31-128 in SHIFT, so W cannot wrap. Negation of 0 yields 0.
- -0.0 (0x80000000) gives 0 with no flags.

Test Plan:
- fp_in=0x40490FDB (3.14159) -> int_out=0x00000003, inexact=1, overflow=0; N=22, out_valid at T+25.
- fp_in=0xC7C35000 (-100000.0) -> int_out=0xFFFE7960, inexact=0, overflow=0; out_valid at T+10.
- fp_in=0x4EFFFFFF -> 0x7FFFFF80, flags 0.
- fp_in=0x4F000000 -> 0x7FFFFFFF, overflow=1.
- fp_in=0xCF000000 -> 0x80000000, overflow=0.
- fp_in=0x7FC00000 -> 0x7FFFFFFF, overflow=1.
- fp_in=0xFF800000 -> 0x80000000, overflow=1.
- fp_in=0x3F000000 -> 0, inexact=1.
- fp_in=0x00000000 and 0x80000000 -> 0, flags 0; out_valid at T+3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid on 0x40490FDB -> int_out and flags stable, in_ready=0, a concurrent in_valid with 0x3F800000 is ignored. After out_ready=1, in_ready=1 next cycle, and 0x3F800000 then yields 0x00000001.
- Reset mid-SHIFT: start 0x40490FDB, assert rst at T+10 for one cycle -> next cycle out_valid=0, int_out=0, flags 0, in_ready=1, no stale result appears. A fresh 0xC7C35000 then converts correctly.
